hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-003 id_rs, id_rt  in  5 each  source register fields of the instruction in IF/ID.
REQ-004 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-005 ex_memread  in  1  MemRead bit of the ID/EX M-control field.
REQ-006 ex_rt  in  5  rt field (bits 20:16) held in ID/EX.
REQ-007 branch_taken  in  1  branch resolved taken in MEM this cycle.
REQ-008 mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-009 pc_write, ifid_write  out  1 each  enables for PC and IF/ID.
REQ-010 ifid_flush, idex_bubble, exmem_flush  out  1 each  zero the respective buffer contents/controls.
REQ-011 idex_write, exmem_write  out  1 each  enables for ID/EX and EX/MEM.
REQ-012 state  out  2  current FSM state, for debug.
REQ-013 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-014 FSM states SHALL be RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-015 Control outputs SHALL be combinational from the current inputs and state, with zero-cycle latency.
REQ-016 load_use SHALL be ex_memread AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-017 Priority SHALL be mem_busy > branch_taken > load_use > none.
REQ-018 When mem_busy=1, all *_write outputs SHALL be 0, all flush/bubble outputs SHALL be 0, and the next state SHALL be MEM_WAIT.
REQ-019 When branch_taken=1 and mem_busy=0, ifid_flush, idex_bubble and exmem_flush SHALL be 1, pc_write SHALL be 1, and the next state SHALL be FLUSH.
REQ-020 When load_use=1 and no higher event is active, pc_write=0, ifid_write=0 and idex_bubble=1 SHALL hold, EX/MEM SHALL write, and the next state SHALL be LU_STALL.
REQ-021 In LU_STALL, load_use SHALL be ignored for that one cycle, so two consecutive bubbles never occur for the same load.
REQ-022 With no event active, every *_write output SHALL be 1, every flush/bubble output SHALL be 0, and the next state SHALL be RUN.
REQ-023 In MEM_WAIT with mem_busy falling to 0, the remaining events SHALL be evaluated normally in that same cycle.
REQ-024 stall_cnt SHALL increment by one on each cycle that load_use or mem_busy is acted on, and SHALL saturate at 0xFFFF.
REQ-025 flush_cnt SHALL increment by one on each acted branch_taken cycle, and SHALL saturate at 0xFFFF.
REQ-026 When branch_taken and load_use occur simultaneously, only the flush SHALL apply and stall_cnt SHALL NOT increment.

Reset
REQ-027 While rst=1: state=RUN, stall_cnt=0 and flush_cnt=0 at the next edge.
REQ-028 While rst=1: pc_write=0, all other *_write outputs=0, and ifid_flush, idex_bubble, exmem_flush=1.
REQ-029 Reset asserted mid-stall or mid-flush SHALL take effect at the next edge, and no counter update SHALL occur in that cycle.
REQ-030 On the first cycle after rst falls, the block SHALL behave as RUN.

Structure
REQ-031 A shared package SHALL hold the state encodings, the 16-bit counter width and the zero-register constant.
REQ-032 One sub-module, sat_counter16 (enable, synchronous clear, saturate), SHALL be instantiated twice.
REQ-033 The hazard detection comparator SHALL remain inline combinational logic.

Verification
REQ-034 Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle, then state=RUN and stall_cnt=1.
REQ-035 Register zero: ex_memread=1, ex_rt=0, id_rs=0 -> no stall, all writes=1.
REQ-036 rt gating: ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall; the same with id_uses_rt=1 -> stall.
REQ-037 Simultaneous: branch_taken=1 with a load-use match -> all three flush outputs=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
REQ-038 Memory hold: mem_busy=1 for 3 cycles -> all writes=0 for 3 cycles, state=MEM_WAIT, stall_cnt=3; a branch_taken during the hold is ignored until mem_busy=0.
REQ-039 Saturation and reset: force 65537 stall cycles -> stall_cnt=0xFFFF; assert rst for one cycle -> both counters=0 and state=RUN.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: FSM state encodings,
// performance counter width and the hard-wired zero register index.
package hazard_unit_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_unit_sat_counter16.sv
// Event counter with synchronous clear that sticks at its maximum value
// instead of wrapping.
module sat_counter16
  import hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: resolves memory holds, taken-branch flushes and
// load-use stalls, and counts the stall and flush cycles it acts on.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             idex_write,
  output logic             exmem_write,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e state_q;
  state_e state_d;
  logic   load_use_match;
  logic   load_use;
  logic   stall_en;
  logic   flush_en;

  assign load_use_match = ex_memread && (ex_rt != ZERO_REG) &&
                          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // The cycle after a bubble the load has moved on, so a repeat match is stale.
  assign load_use = load_use_match && (state_q != LU_STALL);

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    stall_en    = 1'b0;
    flush_en    = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_busy) begin
      state_d     = MEM_WAIT;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      stall_en    = 1'b1;
    end else if (branch_taken) begin
      state_d     = FLUSH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      flush_en    = 1'b1;
    end else if (load_use) begin
      state_d     = LU_STALL;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_en    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall_en),
    .count (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (flush_en),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: reset, load-use detection,
// register-zero and rt gating, branch priority, memory hold, saturation.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_flush;
  logic        idex_write;
  logic        exmem_write;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int pass_cnt;
  int total_cnt;

  // {pc, ifid, idex, exmem writes, ifid_flush, idex_bubble, exmem_flush}
  logic [6:0] ctrl;
  assign ctrl = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_bubble, exmem_flush};

  localparam logic [6:0] CTRL_RUN   = 7'b1111_000;
  localparam logic [6:0] CTRL_RST   = 7'b0000_111;
  localparam logic [6:0] CTRL_LU    = 7'b0011_010;
  localparam logic [6:0] CTRL_HOLD  = 7'b0000_000;
  localparam logic [6:0] CTRL_FLUSH = 7'b1111_111;

  hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_flush  (exmem_flush),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rs        = 5'd1;
    id_rt        = 5'd2;
    id_uses_rt   = 1'b0;
    ex_memread   = 1'b0;
    ex_rt        = 5'd0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RST) $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, CTRL_RST);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({state, stall_cnt, flush_cnt} !== 34'd0)
      $display("[TB] FAIL reset_state: got state=%0d stall=%0d flush=%0d expected 0/0/0", state, stall_cnt, flush_cnt);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RUN) $display("[TB] FAIL post_reset_run: got %b expected %b", ctrl, CTRL_RUN);
    else pass_cnt++;
    step();
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_LU) $display("[TB] FAIL lu_ctrl: got %b expected %b", ctrl, CTRL_LU);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd1 || stall_cnt !== 16'd1)
      $display("[TB] FAIL lu_state: got state=%0d stall=%0d expected 1/1", state, stall_cnt);
    else pass_cnt++;
    // Same match held in LU_STALL must not produce a second bubble
    total_cnt++;
    if (ctrl !== CTRL_RUN) $display("[TB] FAIL lu_no_double: got %b expected %b", ctrl, CTRL_RUN);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd0 || stall_cnt !== 16'd1)
      $display("[TB] FAIL lu_return: got state=%0d stall=%0d expected 0/1", state, stall_cnt);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_reg_zero();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RUN) $display("[TB] FAIL reg_zero_ctrl: got %b expected %b", ctrl, CTRL_RUN);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd0 || stall_cnt !== 16'd1)
      $display("[TB] FAIL reg_zero_state: got state=%0d stall=%0d expected 0/1", state, stall_cnt);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_rt_gating();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RUN) $display("[TB] FAIL rt_unused: got %b expected %b", ctrl, CTRL_RUN);
    else pass_cnt++;
    id_uses_rt = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_LU) $display("[TB] FAIL rt_used: got %b expected %b", ctrl, CTRL_LU);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd1 || stall_cnt !== 16'd2)
      $display("[TB] FAIL rt_state: got state=%0d stall=%0d expected 1/2", state, stall_cnt);
    else pass_cnt++;
    set_idle();
    step();
  endtask

  task automatic test_simultaneous();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_FLUSH) $display("[TB] FAIL simul_ctrl: got %b expected %b", ctrl, CTRL_FLUSH);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd3 || flush_cnt !== 16'd1 || stall_cnt !== 16'd2)
      $display("[TB] FAIL simul_cnt: got state=%0d flush=%0d stall=%0d expected 3/1/2", state, flush_cnt, stall_cnt);
    else pass_cnt++;
    set_idle();
    step();
    total_cnt++;
    if (state !== 2'd0) $display("[TB] FAIL flush_return: got state=%0d expected 0", state);
    else pass_cnt++;
  endtask

  task automatic test_mem_hold();
    int bad;
    bad = 0;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      #1;
      if (ctrl !== CTRL_HOLD) bad++;
      step();
      if (state !== 2'd2) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("[TB] FAIL mem_hold: got %0d bad cycles expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd1)
      $display("[TB] FAIL mem_hold_cnt: got stall=%0d flush=%0d expected 5/1", stall_cnt, flush_cnt);
    else pass_cnt++;
    // Branch still pending as the memory frees up acts in that same cycle
    mem_busy = 1'b0; branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_FLUSH) $display("[TB] FAIL mem_release: got %b expected %b", ctrl, CTRL_FLUSH);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd3 || flush_cnt !== 16'd2)
      $display("[TB] FAIL mem_release_cnt: got state=%0d flush=%0d expected 3/2", state, flush_cnt);
    else pass_cnt++;
    set_idle();
    step();
  endtask

  task automatic test_mid_stall_reset();
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    step();
    total_cnt++;
    if (state !== 2'd1 || stall_cnt !== 16'd6)
      $display("[TB] FAIL pre_reset: got state=%0d stall=%0d expected 1/6", state, stall_cnt);
    else pass_cnt++;
    rst = 1'b1; mem_busy = 1'b1; branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RST) $display("[TB] FAIL mid_reset_ctrl: got %b expected %b", ctrl, CTRL_RST);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({state, stall_cnt, flush_cnt} !== 34'd0)
      $display("[TB] FAIL mid_reset: got state=%0d stall=%0d flush=%0d expected 0/0/0", state, stall_cnt, flush_cnt);
    else pass_cnt++;
    rst = 1'b0;
    set_idle();
    step();
  endtask

  task automatic test_saturation();
    mem_busy = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    total_cnt++;
    if (stall_cnt !== 16'hFFFF || state !== 2'd2)
      $display("[TB] FAIL saturate: got stall=%h state=%0d expected ffff/2", stall_cnt, state);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({state, stall_cnt, flush_cnt} !== 34'd0)
      $display("[TB] FAIL sat_reset: got state=%0d stall=%h flush=%h expected 0/0/0", state, stall_cnt, flush_cnt);
    else pass_cnt++;
    rst = 1'b0;
    set_idle();
    #1;
    total_cnt++;
    if (ctrl !== CTRL_RUN) $display("[TB] FAIL sat_run: got %b expected %b", ctrl, CTRL_RUN);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_load_use();
    test_reg_zero();
    test_rt_gating();
    test_simultaneous();
    test_mem_hold();
    test_mid_stall_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
